// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR random-number core.
package lfsr_pkg;

  // Run-control FSM encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEED  = 2'd1,
    RUN   = 2'd2,
    PAUSE = 2'd3
  } fsm_t;

  // Default maximal-length tap masks (bit i set => state[i] feeds back)
  localparam logic [7:0]  TAPS8  = 8'hB8;
  localparam logic [15:0] TAPS16 = 16'hB400;

endpackage

// File: rtl/lfsr_cfg_chain.sv
// Serial configuration chain: a 2*W-bit shift register ordered {taps, seed}
// plus the commit latch that publishes it as the active taps/seed.
module lfsr_cfg_chain #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift,
  input  logic         din,
  input  logic         commit,
  output logic         dout,
  output logic [W-1:0] taps,
  output logic [W-1:0] seed
);

  logic [2*W-1:0] chain;

  // Shift in MSB first; the chain MSB drops out for daisy-chaining
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        chain <= '0;
    else if (shift) chain <= {chain[2*W-2:0], din};
  end

  // Commit copies the pre-shift chain contents into the active registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps <= '0;
      seed <= '0;
    end else if (commit) begin
      taps <= chain[2*W-1:W];
      seed <= chain[W-1:0];
    end
  end

  assign dout = chain[2*W-1];

endmodule

// File: rtl/lfsr_rng_core.sv
// Fibonacci LFSR with serial config, step divider, lock-up recovery and an
// OUT_W-bit word collector behind a valid/ready handshake.
module lfsr_rng_core
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OUT_W = 4,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_shift,
  input  logic             cfg_din,
  output logic             cfg_dout,
  input  logic             cfg_commit,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             bit_out,
  output logic [OUT_W-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             lockup,
  output logic             overrun
);

  localparam int CW = $clog2(OUT_W + 1);

  logic [WIDTH-1:0] taps;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] seed_eff;
  logic [WIDTH-1:0] state;
  fsm_t             fsm;
  logic [DIV_W-1:0] cnt;
  logic [OUT_W-1:0] coll;
  logic [OUT_W-1:0] coll_nxt;
  logic [OUT_W:0]   coll_ext;
  logic [CW-1:0]    ccnt;
  logic             running;
  logic             tick;
  logic             zero;
  logic             step;
  logic             recover;
  logic             fb;
  logic             word_done;
  logic             accept;

  lfsr_cfg_chain #(.W(WIDTH)) u_chain (
    .clk    (clk),
    .rst    (rst),
    .shift  (cfg_shift),
    .din    (cfg_din),
    .commit (cfg_commit),
    .dout   (cfg_dout),
    .taps   (taps),
    .seed   (seed)
  );

  // A zero seed would park the register in its dead state, so substitute 1
  assign seed_eff = (seed == '0) ? WIDTH'(1) : seed;

  // Stepping is live only in RUN with run held high; commit wins over a step
  assign running   = (fsm == RUN) && run && !cfg_commit;
  assign tick      = running && (cnt == div);
  assign zero      = (state == '0);
  assign recover   = running && zero;
  assign step      = tick && !zero;
  assign fb        = ^(state & taps);

  // Collector shifts in the pre-step MSB; the extended vector keeps OUT_W=1 legal
  assign coll_ext  = {coll, state[WIDTH-1]};
  assign coll_nxt  = coll_ext[OUT_W-1:0];
  assign word_done = step && (ccnt == CW'(OUT_W - 1));
  assign accept    = word_valid && word_ready;

  assign bit_out   = state[WIDTH-1];

  // Run-control FSM; commit re-enters SEED from any state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm <= IDLE;
    end else if (cfg_commit) begin
      fsm <= SEED;
    end else begin
      case (fsm)
        IDLE:    fsm <= IDLE;
        SEED:    fsm <= run ? RUN : PAUSE;
        RUN:     if (!run) fsm <= PAUSE;
        PAUSE:   if (run)  fsm <= RUN;
        default: fsm <= IDLE;
      endcase
    end
  end

  // LFSR state: seed load, lock-up reload, or a Fibonacci shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              state <= '0;
    else if (fsm == SEED && !cfg_commit)  state <= seed_eff;
    else if (recover)                     state <= seed_eff;
    else if (step)                        state <= {state[WIDTH-2:0], fb};
  end

  // Step divider; a div lowered below cnt wraps to 0 without a tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (fsm == SEED) begin
      cnt <= '0;
    end else if (running) begin
      if (recover || cnt >= div) cnt <= '0;
      else                       cnt <= cnt + DIV_W'(1);
    end
  end

  // Bit collector; restarts after every completed word, kept or dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coll <= '0;
      ccnt <= '0;
    end else if (fsm == SEED) begin
      coll <= '0;
      ccnt <= '0;
    end else if (step) begin
      if (word_done) begin
        coll <= '0;
        ccnt <= '0;
      end else begin
        coll <= coll_nxt;
        ccnt <= ccnt + CW'(1);
      end
    end
  end

  // Output word register; a same-cycle accept frees the slot for a new word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_out   <= '0;
      word_valid <= 1'b0;
    end else if (word_done && (!word_valid || word_ready)) begin
      word_out   <= coll_nxt;
      word_valid <= 1'b1;
    end else if (accept) begin
      word_valid <= 1'b0;
    end
  end

  // Sticky status flags, cleared only by commit or reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lockup  <= 1'b0;
      overrun <= 1'b0;
    end else if (cfg_commit) begin
      lockup  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if ((fsm == SEED && seed == '0) || recover)     lockup  <= 1'b1;
      if (word_done && word_valid && !word_ready)     overrun <= 1'b1;
    end
  end

endmodule
